// File: rtl/cell_paint_engine.sv
// Repaints changed game-grid cells as CELL_PX-square RGB565 blocks over an 8080-style 8-bit write bus.
// Updates wait in a small FIFO; scan_en throttles the scanner while one slot of margin remains.
module cell_paint_engine #(
  parameter int FIFO_DEPTH = 4,
  parameter int CELL_PX    = 20
) (
  input  logic       clk,
  input  logic       nrst,
  input  logic       diff,
  input  logic [3:0] x,
  input  logic [3:0] y,
  input  logic [2:0] obj_code,
  input  logic       lcd_ready,
  output logic       scan_en,
  output logic       busy,
  output logic       overflow,
  output logic       lcd_csx,
  output logic       lcd_dcx,
  output logic       lcd_wrx,
  output logic [7:0] lcd_data
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = AW + 1;
  localparam logic [CW-1:0] CNT_FULL = CW'(FIFO_DEPTH);
  localparam logic [CW-1:0] CNT_HI   = CW'(FIFO_DEPTH - 1);
  localparam logic [8:0]    PX       = 9'(CELL_PX);
  localparam logic [8:0]    LAST_PIX = 9'(CELL_PX * CELL_PX - 1);

  typedef struct packed {
    logic [3:0] x;
    logic [3:0] y;
    logic [2:0] obj;
  } cell_t;

  typedef enum logic [2:0] {IDLE, CASET, PASET, RAMWR, PIXELS} state_t;

  cell_t         mem [FIFO_DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [CW-1:0] count;
  logic          fifo_full;
  logic          fifo_empty;
  logic          push;
  logic          pop;

  state_t        state;
  cell_t         cur;
  logic [2:0]    idx;
  logic [8:0]    pix_cnt;
  logic          lo_byte;

  logic [8:0]    x0;
  logic [8:0]    x1;
  logic [8:0]    y0;
  logic [8:0]    y1;
  logic [15:0]   colour;

  // A full FIFO still accepts a push when the head is popped in the same cycle.
  always_comb begin
    fifo_full  = (count == CNT_FULL);
    fifo_empty = (count == '0);
    pop        = (state == IDLE) && !fifo_empty && lcd_ready;
    push       = diff && (!fifo_full || pop);
    busy       = (state != IDLE) || !fifo_empty;
  end

  always_comb begin
    x0 = 9'(cur.x) * PX;
    x1 = x0 + PX - 9'd1;
    y0 = 9'(cur.y) * PX;
    y1 = y0 + PX - 9'd1;
    case (cur.obj)
      3'b001:  colour = 16'hFFE0;
      3'b010:  colour = 16'h07E0;
      3'b011:  colour = 16'hF800;
      3'b100:  colour = 16'h001F;
      default: colour = 16'h0000;
    endcase
  end

  // Data byte k (1..4) of a CASET/PASET window, coordinates zero-extended to 16 bits.
  function automatic logic [7:0] coord_byte(input logic [8:0] c_lo, input logic [8:0] c_hi,
                                            input logic [2:0] k);
    case (k)
      3'd1:    coord_byte = {7'd0, c_lo[8]};
      3'd2:    coord_byte = c_lo[7:0];
      3'd3:    coord_byte = {7'd0, c_hi[8]};
      default: coord_byte = c_hi[7:0];
    endcase
  endfunction

  always_ff @(posedge clk) begin
    if (push) begin
      mem[wr_ptr] <= cell_t'({x, y, obj_code});
    end
  end

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count    <= '0;
      overflow <= 1'b0;
      scan_en  <= 1'b1;
    end else begin
      if (push) begin
        wr_ptr <= wr_ptr + 1'b1;
      end
      if (pop) begin
        rd_ptr <= rd_ptr + 1'b1;
      end
      if (push && !pop) begin
        count <= count + 1'b1;
      end else if (pop && !push) begin
        count <= count - 1'b1;
      end
      if (diff && !push) begin
        overflow <= 1'b1;
      end
      scan_en <= (count < CNT_HI);
    end
  end

  // lcd_wrx doubles as the phase flag: low = phase A, high = phase B of the byte on the bus.
  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      state    <= IDLE;
      cur      <= '0;
      idx      <= '0;
      pix_cnt  <= '0;
      lo_byte  <= 1'b0;
      lcd_csx  <= 1'b1;
      lcd_dcx  <= 1'b1;
      lcd_wrx  <= 1'b1;
      lcd_data <= '0;
    end else if (state == IDLE) begin
      if (pop) begin
        cur      <= mem[rd_ptr];
        state    <= CASET;
        idx      <= '0;
        lcd_csx  <= 1'b0;
        lcd_dcx  <= 1'b0;
        lcd_wrx  <= 1'b0;
        lcd_data <= 8'h2A;
      end
    end else if (!lcd_wrx) begin
      lcd_wrx <= 1'b1;
    end else begin
      lcd_wrx <= 1'b0;
      lcd_dcx <= 1'b1;
      case (state)
        CASET: begin
          if (idx == 3'd4) begin
            state    <= PASET;
            idx      <= '0;
            lcd_dcx  <= 1'b0;
            lcd_data <= 8'h2B;
          end else begin
            idx      <= idx + 3'd1;
            lcd_data <= coord_byte(x0, x1, idx + 3'd1);
          end
        end
        PASET: begin
          if (idx == 3'd4) begin
            state    <= RAMWR;
            idx      <= '0;
            lcd_dcx  <= 1'b0;
            lcd_data <= 8'h2C;
          end else begin
            idx      <= idx + 3'd1;
            lcd_data <= coord_byte(y0, y1, idx + 3'd1);
          end
        end
        RAMWR: begin
          state    <= PIXELS;
          pix_cnt  <= '0;
          lo_byte  <= 1'b0;
          lcd_data <= colour[15:8];
        end
        PIXELS: begin
          if (!lo_byte) begin
            lo_byte  <= 1'b1;
            lcd_data <= colour[7:0];
          end else if (pix_cnt == LAST_PIX) begin
            state   <= IDLE;
            lcd_csx <= 1'b1;
            lcd_wrx <= 1'b1;
          end else begin
            pix_cnt  <= pix_cnt + 9'd1;
            lo_byte  <= 1'b0;
            lcd_data <= colour[15:8];
          end
        end
        default: begin
          state   <= IDLE;
          lcd_csx <= 1'b1;
          lcd_wrx <= 1'b1;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_cell_paint_engine.sv
// Randomised bench for cell_paint_engine: bus bytes are decoded per cell and compared with
// a reference built from the cell coordinates and colour table by plain arithmetic.
module tb_cell_paint_engine;

  localparam int DEPTH = 4;
  localparam int CELL_BYTES = 811;
  localparam int CELL_CLKS = 1622;

  logic       clk;
  logic       nrst;
  logic       diff;
  logic [3:0] x;
  logic [3:0] y;
  logic [2:0] obj_code;
  logic       lcd_ready;
  logic       scan_en;
  logic       busy;
  logic       overflow;
  logic       lcd_csx;
  logic       lcd_dcx;
  logic       lcd_wrx;
  logic [7:0] lcd_data;

  cell_paint_engine #(.FIFO_DEPTH(DEPTH), .CELL_PX(20)) dut (
    .clk(clk), .nrst(nrst), .diff(diff), .x(x), .y(y), .obj_code(obj_code),
    .lcd_ready(lcd_ready), .scan_en(scan_en), .busy(busy), .overflow(overflow),
    .lcd_csx(lcd_csx), .lcd_dcx(lcd_dcx), .lcd_wrx(lcd_wrx), .lcd_data(lcd_data)
  );

  int n_cmp = 0;
  int n_bad = 0;

  logic [8:0]  byte_q [$];
  int          len_q [$];
  int          nb_q [$];
  int          gap_q [$];
  logic [10:0] exp_cells [$];
  int          wr_edges = 0;
  int          unstable = 0;

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #950000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog expired");
  end

  task automatic check_eq(input string tag, input int got, input int exp);
    n_cmp++;
    if (got != exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  // Reference byte i of the 811-byte stream for one cell.
  function automatic logic [8:0] exp_byte(input logic [10:0] c, input int i);
    int cx, cy, x0, x1, y0, y1, col;
    cx = int'(c[10:7]);
    cy = int'(c[6:3]);
    x0 = cx * 20;
    x1 = x0 + 19;
    y0 = cy * 20;
    y1 = y0 + 19;
    case (c[2:0])
      3'd1: col = 'hFFE0;
      3'd2: col = 'h07E0;
      3'd3: col = 'hF800;
      3'd4: col = 'h001F;
      default: col = 0;
    endcase
    case (i)
      0:  return {1'b0, 8'h2A};
      1:  return {1'b1, 8'(x0 / 256)};
      2:  return {1'b1, 8'(x0 % 256)};
      3:  return {1'b1, 8'(x1 / 256)};
      4:  return {1'b1, 8'(x1 % 256)};
      5:  return {1'b0, 8'h2B};
      6:  return {1'b1, 8'(y0 / 256)};
      7:  return {1'b1, 8'(y0 % 256)};
      8:  return {1'b1, 8'(y1 / 256)};
      9:  return {1'b1, 8'(y1 % 256)};
      10: return {1'b0, 8'h2C};
      default: return {1'b1, (((i - 11) % 2) == 0) ? 8'(col / 256) : 8'(col % 256)};
    endcase
  endfunction

  // Bus monitor: bytes latch on wrx rising edges; a cell is one csx-low window.
  initial begin
    logic pw, pc, in_cell;
    logic [8:0] pa;
    int len, gap, cgap;
    logic [8:0] cur_q [$];
    pw = 1'b1; pc = 1'b1; in_cell = 1'b0; pa = '0; len = 0; gap = 0; cgap = 0;
    forever begin
      @(negedge clk);
      if (!nrst) begin
        in_cell = 1'b0; pw = 1'b1; pc = 1'b1; gap = 0;
        cur_q.delete();
        continue;
      end
      if (lcd_wrx && !pw) begin
        wr_edges++;
        if ({lcd_dcx, lcd_data} != pa) unstable++;
        if (in_cell) cur_q.push_back({lcd_dcx, lcd_data});
      end
      if (!lcd_csx) begin
        if (pc) begin
          in_cell = 1'b1; len = 0; cgap = gap;
          cur_q.delete();
        end
        len++;
      end else begin
        if (!pc && in_cell) begin
          len_q.push_back(len);
          gap_q.push_back(cgap);
          nb_q.push_back(cur_q.size());
          foreach (cur_q[k]) byte_q.push_back(cur_q[k]);
          in_cell = 1'b0;
          gap = 1;
        end else begin
          gap++;
        end
      end
      pa = {lcd_dcx, lcd_data};
      pw = lcd_wrx;
      pc = lcd_csx;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    nrst = 1'b0;
    diff = 1'b0;
    lcd_ready = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    nrst = 1'b1;
    tick();
    exp_cells.delete();
  endtask

  task automatic set_rand_cell(output logic [10:0] c);
    x = 4'($urandom_range(0, 15));
    y = 4'($urandom_range(0, 15));
    obj_code = 3'($urandom_range(0, 7));
    c = {x, y, obj_code};
  endtask

  task automatic push_cell(input int cx, input int cy, input int co);
    x = 4'(cx);
    y = 4'(cy);
    obj_code = 3'(co);
    diff = 1'b1;
    tick();
    diff = 1'b0;
    exp_cells.push_back({4'(cx), 4'(cy), 3'(co)});
  endtask

  // Consecutive diffs into an idle, empty engine with lcd_ready low.
  task automatic burst(input int k);
    int cnt, prev;
    bit ovf;
    logic [10:0] c;
    cnt = 0;
    ovf = 1'b0;
    for (int i = 0; i < k; i++) begin
      set_rand_cell(c);
      diff = 1'b1;
      prev = cnt;
      tick();
      if (cnt < DEPTH) begin
        cnt++;
        exp_cells.push_back(c);
      end else begin
        ovf = 1'b1;
      end
      check_eq("scan_en_burst", int'(scan_en), int'(prev < DEPTH - 1));
      check_eq("overflow_burst", int'(overflow), int'(ovf));
    end
    diff = 1'b0;
  endtask

  task automatic check_cell();
    int t, len, nb, g, bad;
    logic [10:0] c;
    logic [8:0] b, e;
    t = 0;
    while (len_q.size() == 0 && t < 4000) begin
      @(posedge clk);
      t++;
    end
    #1;
    if (len_q.size() == 0) begin
      check_eq("cell_timeout", 0, 1);
      return;
    end
    len = len_q.pop_front();
    nb = nb_q.pop_front();
    g = gap_q.pop_front();
    check_eq("csx_low_clks", len, CELL_CLKS);
    check_eq("cell_nbytes", nb, CELL_BYTES);
    check_eq("csx_gap", int'(g >= 1), 1);
    if (exp_cells.size() == 0) begin
      check_eq("unexpected_cell", 1, 0);
      for (int i = 0; i < nb; i++) void'(byte_q.pop_front());
      return;
    end
    c = exp_cells.pop_front();
    bad = 0;
    for (int i = 0; i < nb; i++) begin
      b = byte_q.pop_front();
      if (nb == CELL_BYTES) begin
        e = exp_byte(c, i);
        if (i < 11) check_eq($sformatf("hdr_byte%0d", i), int'(b), int'(e));
        else if (b != e) bad++;
      end
    end
    if (nb == CELL_BYTES) check_eq("pixel_bytes_bad", bad, 0);
  endtask

  task automatic drain(input int n);
    for (int i = 0; i < n; i++) check_cell();
  endtask

  initial begin
    logic [10:0] c;
    int k, snap, t;
    nrst = 1'b0; diff = 1'b0; x = '0; y = '0; obj_code = '0; lcd_ready = 1'b0;
    #2;
    do_reset();

    check_eq("rst_csx", int'(lcd_csx), 1);
    check_eq("rst_wrx", int'(lcd_wrx), 1);
    check_eq("rst_dcx", int'(lcd_dcx), 1);
    check_eq("rst_data", int'(lcd_data), 0);
    check_eq("rst_overflow", int'(overflow), 0);
    check_eq("rst_busy", int'(busy), 0);
    check_eq("rst_scan_en", int'(scan_en), 1);

    // Directed cells, including the far corner and every distinct colour class.
    lcd_ready = 1'b1;
    push_cell(3, 2, 3);
    check_cell();
    repeat (2) tick();
    check_eq("busy_after_cell", int'(busy), 0);
    push_cell(15, 11, 4);
    check_cell();
    push_cell($urandom_range(0, 15), $urandom_range(0, 11), 6);
    check_cell();
    push_cell($urandom_range(0, 15), $urandom_range(0, 11), 1);
    check_cell();
    push_cell($urandom_range(0, 15), $urandom_range(0, 11), 2);
    check_cell();

    // Five diffs with the panel held off: four stored, one dropped.
    lcd_ready = 1'b0;
    tick();
    burst(5);
    check_eq("busy_queued", int'(busy), 1);
    check_eq("no_paint_unready", len_q.size() + int'(!lcd_csx), 0);
    lcd_ready = 1'b1;
    drain(4);
    repeat (3) tick();
    check_eq("overflow_sticky", int'(overflow), 1);
    check_eq("scan_en_drained", int'(scan_en), 1);

    // Reset while pixels stream.
    set_rand_cell(c);
    push_cell(int'(c[10:7]), int'(c[6:3]), int'(c[2:0]));
    t = 0;
    while (lcd_csx && t < 50) begin tick(); t++; end
    check_eq("cell_started", int'(lcd_csx), 0);
    repeat (100) @(posedge clk);
    #3;
    nrst = 1'b0;
    #1;
    check_eq("async_csx", int'(lcd_csx), 1);
    check_eq("async_wrx", int'(lcd_wrx), 1);
    check_eq("async_data", int'(lcd_data), 0);
    repeat (2) @(negedge clk);
    nrst = 1'b1;
    exp_cells.delete();
    tick();
    check_eq("post_rst_busy", int'(busy), 0);
    check_eq("post_rst_overflow", int'(overflow), 0);
    check_eq("post_rst_scan_en", int'(scan_en), 1);
    snap = wr_edges;
    repeat (100) tick();
    check_eq("quiet_bus", wr_edges - snap, 0);
    check_eq("no_partial_cell", len_q.size(), 0);
    push_cell($urandom_range(0, 15), $urandom_range(0, 11), $urandom_range(0, 7));
    check_cell();

    // Push coinciding with a pop from a full FIFO.
    lcd_ready = 1'b0;
    tick();
    burst(4);
    set_rand_cell(c);
    lcd_ready = 1'b1;
    diff = 1'b1;
    tick();
    diff = 1'b0;
    exp_cells.push_back(c);
    check_eq("ovf_same_cycle", int'(overflow), 0);
    repeat (2) tick();
    check_eq("scan_en_still_full", int'(scan_en), 0);
    drain(5);

    // Random bursts.
    for (int it = 0; it < 4; it++) begin
      do_reset();
      k = $urandom_range(1, 6);
      burst(k);
      check_eq("rand_overflow", int'(overflow), int'(k > DEPTH));
      lcd_ready = 1'b1;
      drain((k > DEPTH) ? DEPTH : k);
      repeat (3) tick();
      check_eq("rand_busy_done", int'(busy), 0);
      check_eq("rand_scan_en", int'(scan_en), 1);
    end

    check_eq("phase_b_stable", unstable, 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
